// File: rtl/clock24_pkg.sv
// Shared clock24 definitions: mode codes, button bit positions, blink mask decode.
// Used by the set controller, the counter datapath and the display driver.
// Pure definitions; no timing or flow control.
package clock24_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    localparam int BTN_MODE   = 0;
    localparam int BTN_SELECT = 1;
    localparam int BTN_UP     = 2;

    // Mask order is {hour, min, sec}; only the field being edited can blink.
    function automatic logic [2:0] blink_mask(input state_t st, input logic ph);
        case (st)
            ST_SET_HOUR: blink_mask = {ph, 2'b00};
            ST_SET_MIN:  blink_mask = {1'b0, ph, 1'b0};
            ST_SET_SEC:  blink_mask = {2'b00, ph};
            default:     blink_mask = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/setctl_timeout.sv
// Inactivity counter for set mode: clears, counts 1 Hz ticks, flags expiry.
// expire is combinational from the count register and tick; the caller registers its effect.
// No backpressure; clear has priority over tick.
module setctl_timeout #(
    parameter int TIMEOUT = 30
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic tick,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = tick && (cnt == LAST);

endmodule

// File: rtl/clock24_setctl.sv
// Time-setting controller: mode FSM, increment/clear pulses, blink mask, inactivity exit.
// Button to output latency is one cycle; every output is registered or a state decode.
// No backpressure; simultaneous buttons resolve MODE > SELECT > UP and losers are dropped.
module clock24_setctl
    import clock24_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic [2:0] BTN,
    output logic       CNTEN,
    output logic       HOURINC,
    output logic       MININC,
    output logic       SECCLR,
    output logic [1:0] STATE,
    output logic [2:0] BLINK
);

    state_t state;
    state_t state_nxt;
    logic   phase;
    logic   phase_nxt;
    logic   hourinc_nxt;
    logic   mininc_nxt;
    logic   secclr_nxt;
    logic   to_clr;
    logic   to_tick;
    logic   to_expire;
    logic   in_set;

    assign in_set  = (state != ST_NORMAL);
    // Any button in set mode counts as activity, even one that loses arbitration.
    assign to_clr  = !in_set || (|BTN);
    assign to_tick = in_set && EN1HZ;

    setctl_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (to_clr),
        .tick  (to_tick),
        .expire(to_expire)
    );

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        hourinc_nxt = 1'b0;
        mininc_nxt  = 1'b0;
        secclr_nxt  = 1'b0;
        if (!in_set) begin
            phase_nxt = 1'b0;
            if (BTN[BTN_MODE]) begin
                state_nxt = ST_SET_HOUR;
            end
        end else if (BTN[BTN_MODE]) begin
            state_nxt = ST_NORMAL;
            phase_nxt = 1'b0;
        end else if (BTN[BTN_SELECT]) begin
            phase_nxt = 1'b0;
            case (state)
                ST_SET_HOUR: state_nxt = ST_SET_MIN;
                ST_SET_MIN:  state_nxt = ST_SET_SEC;
                default:     state_nxt = ST_SET_HOUR;
            endcase
        end else if (BTN[BTN_UP]) begin
            phase_nxt = 1'b0;
            case (state)
                ST_SET_HOUR: hourinc_nxt = 1'b1;
                ST_SET_MIN:  mininc_nxt  = 1'b1;
                default:     secclr_nxt  = 1'b1;
            endcase
        end else if (EN1HZ) begin
            // A coincident button already took the branches above, so expiry only fires when idle.
            if (to_expire) begin
                state_nxt = ST_NORMAL;
                phase_nxt = 1'b0;
            end else begin
                phase_nxt = ~phase;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_NORMAL;
            phase   <= 1'b0;
            HOURINC <= 1'b0;
            MININC  <= 1'b0;
            SECCLR  <= 1'b0;
            BLINK   <= 3'b000;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            HOURINC <= hourinc_nxt;
            MININC  <= mininc_nxt;
            SECCLR  <= secclr_nxt;
            BLINK   <= blink_mask(state_nxt, phase_nxt);
        end
    end

    assign STATE = state;
    assign CNTEN = (state == ST_NORMAL);

endmodule
